// File: rtl/rsa_pkg.sv
// Shared types for the RSA decrypt unit: control FSM states and default operand width.
package rsa_pkg;

  localparam int RSA_DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    MUL,
    UPD,
    DONE
  } rsa_state_t;

endpackage

// File: rtl/modmul_serial.sv
// Serial modular multiplier r = a*b mod n (requires b < n), one bit of a per cycle, MSB first.
// Latency: WIDTH cycles starting with the load cycle; done marks the last step; no backpressure.
module modmul_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = WIDTH + 2;

  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [CW-1:0]    left;
  logic             run;

  logic             bit_cur;
  logic [AW-1:0]    acc_base;
  logic [AW-1:0]    b_ext;
  logic [AW-1:0]    n_ext;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    sub1;
  logic [AW-1:0]    step;

  // The load cycle already performs the first step on the live operands,
  // so a product takes exactly WIDTH cycles with no separate setup cycle.
  always_comb begin
    acc_base = load ? '0 : acc;
    bit_cur  = load ? a[WIDTH-1] : a_sh[WIDTH-1];
    b_ext    = {2'b00, (load ? b : b_q)};
    n_ext    = {2'b00, (load ? n : n_q)};
    sum      = (acc_base << 1) + (bit_cur ? b_ext : '0);
    sub1     = (sum >= n_ext) ? (sum - n_ext) : sum;
    step     = (sub1 >= n_ext) ? (sub1 - n_ext) : sub1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      a_sh <= '0;
      b_q  <= '0;
      n_q  <= '0;
      left <= '0;
      run  <= 1'b0;
    end else if (load) begin
      acc  <= step;
      a_sh <= a << 1;
      b_q  <= b;
      n_q  <= n;
      left <= CW'(WIDTH - 1);
      run  <= 1'b1;
    end else if (run) begin
      acc  <= step;
      a_sh <= a_sh << 1;
      left <= left - 1'b1;
      if (left == CW'(1)) begin
        run <= 1'b0;
      end
    end
  end

  assign r    = acc[WIDTH-1:0];
  assign done = run && (left == CW'(1));

endmodule

// File: rtl/rsa_decrypt_unit.sv
// RSA decryption M = C^D mod N by right-to-left square-and-multiply over two serial multipliers.
// Latency: eoc 1+WIDTH+WIDTH*(WIDTH+1) cycles after start (2 when N < 2); start ignored while busy.
module rsa_decrypt_unit
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] M,
  output logic             busy,
  output logic             eoc,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);

  rsa_state_t       state;
  rsa_state_t       state_n;

  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] r_q;
  logic [IW-1:0]    i_q;
  logic             fresh;
  logic             n_bad;
  logic             last_bit;

  logic             load_init;
  logic             load_mul;
  logic             sq_load;
  logic [WIDTH-1:0] sq_a;
  logic [WIDTH-1:0] sq_b;
  logic [WIDTH-1:0] sq_r;
  logic             sq_done;
  logic [WIDTH-1:0] mul_r;
  logic             mul_done;
  logic [WIDTH-1:0] r_next;

  assign n_bad    = (n_q < WIDTH'(2));
  assign last_bit = (i_q == IW'(WIDTH - 1));
  assign r_next   = d_q[i_q] ? mul_r : r_q;
  assign sq_load  = load_init | load_mul;

  // B lives in the square-path accumulator: C mod N after INIT, B*B after
  // every MUL, so it is fed straight back as both operands of the next square.
  always_comb begin
    state_n   = state;
    load_init = 1'b0;
    load_mul  = 1'b0;
    sq_a      = sq_r;
    sq_b      = sq_r;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = INIT;
        end
      end
      INIT: begin
        sq_a = c_q;
        sq_b = WIDTH'(1);
        if (fresh && n_bad) begin
          state_n = DONE;
        end else begin
          load_init = fresh;
          if (sq_done) begin
            state_n = MUL;
          end
        end
      end
      MUL: begin
        load_mul = fresh;
        if (sq_done && mul_done) begin
          state_n = UPD;
        end
      end
      UPD: begin
        state_n = last_bit ? DONE : MUL;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fresh <= 1'b0;
      c_q   <= '0;
      d_q   <= '0;
      n_q   <= '0;
      r_q   <= '0;
      i_q   <= '0;
      M     <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      // Marks the first cycle of INIT/MUL, where the multipliers are loaded.
      fresh <= (state_n != state);
      case (state)
        IDLE: begin
          if (start) begin
            c_q <= C;
            d_q <= D;
            n_q <= N;
            r_q <= WIDTH'(1);
            i_q <= '0;
            err <= 1'b0;
          end
        end
        INIT: begin
          if (fresh && n_bad) begin
            M   <= '0;
            err <= 1'b1;
          end
        end
        UPD: begin
          r_q <= r_next;
          i_q <= i_q + 1'b1;
          if (last_bit) begin
            M <= r_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign eoc  = (state == DONE);

  modmul_serial #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .load(load_mul),
    .a   (r_q),
    .b   (sq_r),
    .n   (n_q),
    .r   (mul_r),
    .done(mul_done)
  );

  modmul_serial #(
    .WIDTH(WIDTH)
  ) u_sq (
    .clk (clk),
    .rst (rst),
    .load(sq_load),
    .a   (sq_a),
    .b   (sq_b),
    .n   (n_q),
    .r   (sq_r),
    .done(sq_done)
  );

endmodule

// File: tb/tb_rsa_decrypt_unit.sv
// Scoreboard bench for rsa_decrypt_unit: expected results come from plain modular exponentiation.
module tb_rsa_decrypt_unit;

  localparam int W   = 8;
  localparam int LAT = 1 + W + W * (W + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] C;
  logic [W-1:0] D;
  logic [W-1:0] N;
  logic [W-1:0] M;
  logic         busy;
  logic         eoc;
  logic         err;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int m;
    int err;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  rsa_decrypt_unit #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .C    (C),
    .D    (D),
    .N    (N),
    .M    (M),
    .busy (busy),
    .eoc  (eoc),
    .err  (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int ref_modexp(input int c, input int d, input int n);
    longint r;
    if (n < 2) return 0;
    r = 1 % n;
    for (int k = 0; k < d; k++) r = (r * c) % n;
    return int'(r);
  endfunction

  // Monitor: every eoc must match the oldest outstanding expectation.
  exp_t e;
  always @(negedge clk) begin
    if (eoc === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_eoc", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("M", int'(M), e.m);
        check("err", int'(err), e.err);
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input int c, input int d, input int n, input bit expect_it);
    int guard;
    exp_t x;
    guard = 0;
    while (busy && guard < 2 * LAT) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("idle_timeout", 1, 0);
    if (expect_it) begin
      x.m   = ref_modexp(c, d, n);
      x.err = (n < 2) ? 1 : 0;
      x.cyc = cyc + ((n < 2) ? 2 : LAT);
      exp_q.push_back(x);
    end
    C     = c[W-1:0];
    D     = d[W-1:0];
    N     = n[W-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int guard;
    rst   = 1'b1;
    start = 1'b0;
    C     = '0;
    D     = '0;
    N     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_eoc", int'(eoc), 0);
    check("rst_err", int'(err), 0);
    check("rst_M", int'(M), 0);
    // start together with rst must be ignored
    start = 1'b1;
    C = 8'd48; D = 8'd103; N = 8'd143;
    @(negedge clk);
    check("start_in_rst_busy", int'(busy), 0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    issue(48, 103, 143, 1);
    issue(191, 103, 143, 1);
    issue(0, 5, 143, 1);
    issue(5, 0, 143, 1);
    issue(77, 200, 1, 1);
    issue(30, 3, 0, 1);
    issue(255, 255, 255, 1);
    issue(254, 1, 2, 1);

    // start while busy: ten cycles in, different operands, must be ignored
    issue(48, 103, 143, 1);
    repeat (9) @(negedge clk);
    C = 8'd7; D = 8'd11; N = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // reset 40 cycles into an operation aborts it without an eoc
    issue(123, 45, 211, 0);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_M", int'(M), 0);
    check("abort_eoc", int'(eoc), 0);
    check("abort_err", int'(err), 0);
    rst = 1'b0;
    issue(60, 7, 97, 1);

    for (int t = 0; t < 1000; t++) begin
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(2, 255)), 1);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 2 * LAT) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) check("drain_outstanding", exp_q.size(), 0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
